// File: rtl/booth_wallace_ctrl.sv
// rtl/booth_wallace_ctrl.sv - radix-4 Booth encoder and sequencer for an external Wallace tree
// Two requesters share one multiplier. The external tree sums pp_bus into wallace_sum.
// Build option: BOOTH_WALLACE_CTRL_RR_ARB_EN selects round-robin arbitration.
// When it is left undefined, requester 0 has fixed priority.
module booth_wallace_ctrl #(
  parameter int unsigned RED_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [31:0]   req0_a,
  input  logic [31:0]   req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [31:0]   req1_a,
  input  logic [31:0]   req1_b,
  output logic [1023:0] pp_bus,
  input  logic [63:0]   wallace_sum,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [63:0]   res_p,
  output logic          res_src,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ENC, RED, DONE} state_t;

  localparam logic [3:0] RED_LOAD = 4'(RED_CYCLES);

  state_t        state_q, state_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic          src_q, src_d;
  logic [1023:0] pp_q, pp_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [63:0]   res_p_q, res_p_d;
  logic          res_src_q, res_src_d;
  logic          grant0, grant1;
  logic [1023:0] booth_pp;
  logic [32:0]   b_ext;
`ifdef BOOTH_WALLACE_CTRL_RR_ARB_EN
  logic          rr_last_q, rr_last_d;
`endif

  // One Booth digit: select 0, +-a or +-2a, then weight it by 4^k.
  function automatic logic [63:0] booth_digit(input logic [31:0] a, input logic [2:0] sel,
                                              input int k);
    logic [63:0] a64;
    logic [63:0] m;
    a64 = {{32{a[31]}}, a};
    case (sel)
      3'b001, 3'b010: m = a64;
      3'b011:         m = a64 << 1;
      3'b100:         m = -(a64 << 1);
      3'b101, 3'b110: m = -a64;
      default:        m = '0;
    endcase
    return m << (2 * k);
  endfunction

  // Arbitration winner among valid requesters. Only requesters whose valid is high can win.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
`ifdef BOOTH_WALLACE_CTRL_RR_ARB_EN
    if (req0_valid && req1_valid) begin
      grant0 = rr_last_q;
      grant1 = ~rr_last_q;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
`else
    grant0 = req0_valid;
    grant1 = req1_valid & ~req0_valid;
`endif
  end

  // Readies exist only in IDLE and never while reset is asserted.
  always_comb begin
    req0_ready = (state_q == IDLE) && !rst && grant0;
    req1_ready = (state_q == IDLE) && !rst && grant1;
  end

  // Partial products from the captured operands. b is extended with b[-1] = 0 below bit 0.
  always_comb begin
    booth_pp = '0;
    b_ext    = {b_q, 1'b0};
    for (int k = 0; k < 16; k++) begin
      booth_pp[64*k +: 64] = booth_digit(a_q, b_ext[2*k +: 3], k);
    end
  end

  // Next-state logic and datapath updates for the IDLE/ENC/RED/DONE sequence.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    src_d     = src_q;
    pp_d      = pp_q;
    cnt_d     = cnt_q;
    res_p_d   = res_p_q;
    res_src_d = res_src_q;
`ifdef BOOTH_WALLACE_CTRL_RR_ARB_EN
    rr_last_d = rr_last_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          a_d     = req1_ready ? req1_a : req0_a;
          b_d     = req1_ready ? req1_b : req0_b;
          src_d   = req1_ready;
          state_d = ENC;
`ifdef BOOTH_WALLACE_CTRL_RR_ARB_EN
          rr_last_d = req1_ready;
`endif
        end
      end
      ENC: begin
        pp_d    = booth_pp;
        cnt_d   = RED_LOAD;
        state_d = RED;
      end
      RED: begin
        // pp_bus stays frozen here; the tree output is taken on the final count.
        if (cnt_q <= 4'd1) begin
          res_p_d   = wallace_sum;
          res_src_d = src_q;
          cnt_d     = 4'd0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      src_q     <= 1'b0;
      pp_q      <= '0;
      cnt_q     <= 4'd0;
      res_p_q   <= '0;
      res_src_q <= 1'b0;
`ifdef BOOTH_WALLACE_CTRL_RR_ARB_EN
      rr_last_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      src_q     <= src_d;
      pp_q      <= pp_d;
      cnt_q     <= cnt_d;
      res_p_q   <= res_p_d;
      res_src_q <= res_src_d;
`ifdef BOOTH_WALLACE_CTRL_RR_ARB_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

  // Output drive.
  always_comb begin
    pp_bus    = pp_q;
    res_valid = (state_q == DONE);
    res_p     = res_p_q;
    res_src   = res_src_q;
    busy      = (state_q != IDLE);
  end

endmodule
